// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data memory (DM).
// One transaction at a time: grant in IDLE, strobe memory in ISSUE, wait out the
// fixed latency in WAIT, then return data to the owner.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned DM_PRIORITY = 1
) (
   input  logic              clk_i,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_gnt_o,
   output logic              dm_rvalid_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;   // 1 = DM owns the transaction
   logic              last_q, last_d;     // 1 = DM won the last grant
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              pick_dm;
   logic              gnt_if, gnt_dm, rv_if, rv_dm;
   logic [DATA_W-1:0] rdata_if, rdata_dm;

   // Next-state, latching and combinational grant/return logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      last_d   = last_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      gnt_if   = 1'b0;
      gnt_dm   = 1'b0;
      rv_if    = 1'b0;
      rv_dm    = 1'b0;
      rdata_if = '0;
      rdata_dm = '0;

      // On a tie: fixed mode favours DM, round-robin favours whoever lost last time
      if (dm_req_i && if_req_i) begin
         pick_dm = (DM_PRIORITY != 0) || !last_q;
      end else begin
         pick_dm = dm_req_i;
      end

      unique case (state_q)
         StIdle: begin
            if (if_req_i || dm_req_i) begin
               if (pick_dm) begin
                  gnt_dm  = 1'b1;
                  owner_d = 1'b1;
                  we_d    = dm_we_i;
                  addr_d  = dm_addr_i;
                  wdata_d = dm_wdata_i;
               end else begin
                  gnt_if  = 1'b1;
                  owner_d = 1'b0;
                  we_d    = 1'b0;
                  addr_d  = if_addr_i;
                  wdata_d = '0;
               end
               last_d  = pick_dm;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = CNT_LOAD;
            state_d = StWait;
         end
         StWait: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (owner_q) begin
                  rv_dm    = 1'b1;
                  rdata_dm = we_q ? '0 : mem_rdata_i;
               end else begin
                  rv_if    = 1'b1;
                  rdata_if = mem_rdata_i;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and transaction registers
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Everything is forced quiet while reset is asserted, including the cycle it first rises
   assign if_gnt_o    = gnt_if & ~reset;
   assign dm_gnt_o    = gnt_dm & ~reset;
   assign if_rvalid_o = rv_if & ~reset;
   assign dm_rvalid_o = rv_dm & ~reset;
   assign if_rdata_o  = reset ? '0 : rdata_if;
   assign dm_rdata_o  = reset ? '0 : rdata_dm;
   assign mem_en_o    = (state_q == StIssue) & ~reset;
   assign mem_we_o    = (state_q == StIssue) & we_q & ~reset;
   assign mem_addr_o  = reset ? '0 : addr_q;
   assign mem_wdata_o = reset ? '0 : wdata_q;
   assign busy_o      = (state_q != StIdle) & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: dut0 fixed DM priority (latency 2),
// dut1 round-robin (latency 2), dut2 round-robin (latency 1).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        if_req[3];
   logic [31:0] if_addr[3];
   logic        if_gnt[3];
   logic        if_rvalid[3];
   logic [31:0] if_rdata[3];
   logic        dm_req[3];
   logic        dm_we[3];
   logic [31:0] dm_addr[3];
   logic [31:0] dm_wdata[3];
   logic        dm_gnt[3];
   logic        dm_rvalid[3];
   logic [31:0] dm_rdata[3];
   logic        mem_en[3];
   logic        mem_we[3];
   logic [31:0] mem_addr[3];
   logic [31:0] mem_wdata[3];
   logic [31:0] mem_rdata[3];
   logic        busy[3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          dut;
      logic        dm;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   ev_t gq[$];  // expected grants
   ev_t rq[$];  // expected returns

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEAD_BEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned ML = (g == 2) ? 1 : 2;
      localparam int unsigned PR = (g == 0) ? 1 : 0;

      logic        act;
      int unsigned k;
      logic [31:0] la;

      mem_port_arbiter #(
         .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML), .DM_PRIORITY(PR)
      ) u_dut (
         .clk_i(clk), .reset(reset),
         .if_req_i(if_req[g]), .if_addr_i(if_addr[g]), .if_gnt_o(if_gnt[g]),
         .if_rvalid_o(if_rvalid[g]), .if_rdata_o(if_rdata[g]),
         .dm_req_i(dm_req[g]), .dm_we_i(dm_we[g]), .dm_addr_i(dm_addr[g]),
         .dm_wdata_i(dm_wdata[g]), .dm_gnt_o(dm_gnt[g]),
         .dm_rvalid_o(dm_rvalid[g]), .dm_rdata_o(dm_rdata[g]),
         .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
         .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]), .busy_o(busy[g])
      );

      // Fixed-latency memory: data valid only ML cycles after the strobe cycle
      always @(posedge clk) begin
         if (reset) begin
            act <= 1'b0;
         end else if (mem_en[g]) begin
            act <= 1'b1;
            k   <= ML - 1;
            la  <= mem_addr[g];
         end else if (act) begin
            if (k == 0) act <= 1'b0;
            else        k   <= k - 1;
         end
      end
      assign mem_rdata[g] = (act && k == 0) ? mem_val(la) : 32'hBAD0_BAD0;
   end

   task automatic monitor();
      ev_t         e;
      logic [31:0] rd;
      for (int d = 0; d < 3; d++) begin
         while (gq.size() > 0 && gq[0].cyc < cyc) begin
            e = gq.pop_front();
            checks++; errors++;
            $display("FAIL missed_gnt dut%0d: no grant seen, required dm=%0b at cycle %0d",
                     e.dut, e.dm, e.cyc);
         end
         while (rq.size() > 0 && rq[0].cyc < cyc) begin
            e = rq.pop_front();
            checks++; errors++;
            $display("FAIL missed_rvalid dut%0d: no rvalid seen, required dm=%0b at cycle %0d",
                     e.dut, e.dm, e.cyc);
         end
         if (if_gnt[d] || dm_gnt[d]) begin
            checks++;
            if (if_gnt[d] && dm_gnt[d]) begin
               errors++;
               $display("FAIL dual_gnt dut%0d cycle %0d: both grants high, required one", d, cyc);
            end else if (gq.size() == 0) begin
               errors++;
               $display("FAIL extra_gnt dut%0d cycle %0d: got dm=%0b, required none",
                        d, cyc, dm_gnt[d]);
            end else begin
               e = gq.pop_front();
               if (e.dut != d || e.dm !== dm_gnt[d] || e.cyc != cyc) begin
                  errors++;
                  $display("FAIL gnt dut%0d: got dm=%0b at cycle %0d, required dut%0d dm=%0b at %0d",
                           d, dm_gnt[d], cyc, e.dut, e.dm, e.cyc);
               end
            end
         end
         if (if_rvalid[d] || dm_rvalid[d]) begin
            checks++;
            rd = dm_rvalid[d] ? dm_rdata[d] : if_rdata[d];
            if (if_rvalid[d] && dm_rvalid[d]) begin
               errors++;
               $display("FAIL dual_rvalid dut%0d cycle %0d: both rvalids high", d, cyc);
            end else if (rq.size() == 0) begin
               errors++;
               $display("FAIL extra_rvalid dut%0d cycle %0d: got dm=%0b data=%h, required none",
                        d, cyc, dm_rvalid[d], rd);
            end else begin
               e = rq.pop_front();
               if (e.dut != d || e.dm !== dm_rvalid[d] || e.cyc != cyc || rd !== e.data) begin
                  errors++;
                  $display("FAIL rvalid dut%0d: got dm=%0b data=%h cycle %0d, required dut%0d dm=%0b data=%h cycle %0d",
                           d, dm_rvalid[d], rd, cyc, e.dut, e.dm, e.data, e.cyc);
               end
            end
         end
         if ((!if_rvalid[d] && if_rdata[d] !== '0) || (!dm_rvalid[d] && dm_rdata[d] !== '0)) begin
            checks++; errors++;
            $display("FAIL rdata_idle dut%0d cycle %0d: got if=%h dm=%h, required 0",
                     d, cyc, if_rdata[d], dm_rdata[d]);
         end
      end
   endtask

   // Sample at negedge, then advance to just after the next rising edge
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      for (int d = 0; d < 3; d++) begin
         if_req[d] = 1'b0; if_addr[d] = '0;
         dm_req[d] = 1'b0; dm_we[d] = 1'b0; dm_addr[d] = '0; dm_wdata[d] = '0;
      end
   endtask

   task automatic test_reset();
      int t;
      if_req[0] = 1'b1; if_addr[0] = 32'h80;
      dm_req[0] = 1'b1; dm_addr[0] = 32'h40;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({if_gnt[0], dm_gnt[0], if_rvalid[0], dm_rvalid[0], mem_en[0], mem_we[0], busy[0],
              if_rdata[0], dm_rdata[0], mem_addr[0], mem_wdata[0]} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got gnt=%0b%0b en=%0b busy=%0b addr=%h, required all 0",
                     cyc, if_gnt[0], dm_gnt[0], mem_en[0], busy[0], mem_addr[0]);
         end
         tick();
      end
      reset = 1'b0;
      t = cyc;
      gq.push_back('{0, 1'b1, 32'h0, t});
      rq.push_back('{0, 1'b1, mem_val(32'h40), t + 3});
      tick();
      if_req[0] = 1'b0; dm_req[0] = 1'b0;
      repeat (3) tick();
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_busy: got %0b, required 0", busy[0]);
      end
   endtask

   task automatic test_if_read();
      int t = cyc;
      if_req[0] = 1'b1; if_addr[0] = 32'h100;
      gq.push_back('{0, 1'b0, 32'h0, t});
      rq.push_back('{0, 1'b0, 32'hDEAD_BEEF, t + 3});
      tick();
      if_req[0] = 1'b0;
      checks++;
      if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h100 || mem_we[0] !== 1'b0 || busy[0] !== 1'b1)
      begin
         errors++;
         $display("FAIL if_issue: got en=%0b we=%0b addr=%h busy=%0b, required en=1 we=0 addr=100 busy=1",
                  mem_en[0], mem_we[0], mem_addr[0], busy[0]);
      end
      tick();
      checks++;
      if (mem_en[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL if_wait: got en=%0b busy=%0b, required en=0 busy=1", mem_en[0], busy[0]);
      end
      repeat (2) tick();
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL if_done_busy: got %0b, required 0", busy[0]);
      end
   endtask

   task automatic test_dm_write();
      int t = cyc;
      dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h200; dm_wdata[0] = 32'h1234;
      gq.push_back('{0, 1'b1, 32'h0, t});
      rq.push_back('{0, 1'b1, 32'h0, t + 3});
      tick();
      dm_req[0] = 1'b0; dm_we[0] = 1'b0; dm_wdata[0] = '0;
      checks++;
      if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 32'h200 ||
          mem_wdata[0] !== 32'h1234) begin
         errors++;
         $display("FAIL dm_write_issue: got en=%0b we=%0b addr=%h wdata=%h, required 1 1 200 1234",
                  mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
      end
      tick();
      checks++;
      if (mem_we[0] !== 1'b0 || mem_en[0] !== 1'b0 || mem_wdata[0] !== 32'h1234) begin
         errors++;
         $display("FAIL dm_write_wait: got en=%0b we=%0b wdata=%h, required 0 0 1234",
                  mem_en[0], mem_we[0], mem_wdata[0]);
      end
      repeat (2) tick();
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL dm_write_busy: got %0b, required 0", busy[0]);
      end
   endtask

   task automatic test_dm_priority();
      int t = cyc;
      if_req[0] = 1'b1; if_addr[0] = 32'h300;
      dm_req[0] = 1'b1; dm_addr[0] = 32'h400;
      for (int k = 0; k < 3; k++) begin
         gq.push_back('{0, 1'b1, 32'h0, t + 4 * k});
         rq.push_back('{0, 1'b1, mem_val(32'h400), t + 4 * k + 3});
      end
      gq.push_back('{0, 1'b0, 32'h0, t + 12});
      rq.push_back('{0, 1'b0, mem_val(32'h300), t + 15});
      for (int rel = 1; rel <= 16; rel++) begin
         tick();
         if (rel == 9)  dm_req[0] = 1'b0;
         if (rel == 13) if_req[0] = 1'b0;
      end
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL prio_busy: got %0b, required 0", busy[0]);
      end
   endtask

   task automatic test_round_robin(input int d, input int ml);
      int s = ml + 2;
      int t = cyc;
      logic is_dm;
      if_req[d] = 1'b1; if_addr[d] = 32'h700;
      dm_req[d] = 1'b1; dm_addr[d] = 32'h800;
      for (int k = 0; k < 4; k++) begin
         is_dm = (k % 2 == 0);
         gq.push_back('{d, is_dm, 32'h0, t + k * s});
         rq.push_back('{d, is_dm, is_dm ? mem_val(32'h800) : mem_val(32'h700), t + k * s + 1 + ml});
      end
      for (int rel = 1; rel <= 4 * s; rel++) begin
         tick();
         if (rel == 3 * s + 1) begin
            if_req[d] = 1'b0; dm_req[d] = 1'b0;
         end
      end
      checks++;
      if (busy[d] !== 1'b0) begin
         errors++;
         $display("FAIL rr_busy dut%0d: got %0b, required 0", d, busy[d]);
      end
   endtask

   task automatic test_reset_mid();
      int t = cyc;
      if_req[0] = 1'b1; if_addr[0] = 32'h500;
      gq.push_back('{0, 1'b0, 32'h0, t});
      tick();
      if_req[0] = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy[0] !== 1'b0 || if_rvalid[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: got busy=%0b if_rvalid=%0b, required 0 0", busy[0], if_rvalid[0]);
      end
      dm_req[0] = 1'b1; dm_addr[0] = 32'h600;
      gq.push_back('{0, 1'b1, 32'h0, t + 3});
      rq.push_back('{0, 1'b1, mem_val(32'h600), t + 6});
      tick();
      dm_req[0] = 1'b0;
      repeat (3) tick();
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_recover_busy: got %0b, required 0", busy[0]);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_if_read();
      test_dm_write();
      test_dm_priority();
      test_round_robin(1, 2);
      test_round_robin(2, 1);
      test_reset_mid();
      tick();
      checks++;
      if (gq.size() != 0 || rq.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d grants %0d returns outstanding, required 0 0",
                  gq.size(), rq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port, fixed-latency memory between the instruction-fetch (IF) requester and the data-memory (DM, load/store) requester of the pipelined core.
- Sequences each access: grant, issue, wait, return.
- Raises busy_o so the hazard unit can stall the pipeline registers.
- Handles one transaction at a time; selection is either fixed data-first or round-robin.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from the mem_en_o cycle to valid mem_rdata_i. Legal range ≥1.
- DM_PRIORITY, 1, selection mode. 1 = DM always wins a tie. 0 = round-robin on last winner.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_i  in  1  IF request; held with if_addr_i stable until if_gnt_o.
- if_addr_i  in  ADDR_W  IF read address.
- if_gnt_o  out  1  one-cycle grant pulse to IF.
- if_rvalid_o  out  1  one-cycle pulse: IF read data valid.
- if_rdata_o  out  DATA_W  IF read data; 0 when if_rvalid_o is low.
- dm_req_i  in  1  DM request; held until dm_gnt_o.
- dm_we_i  in  1  DM write enable.
- dm_addr_i  in  ADDR_W  DM address.
- dm_wdata_i  in  DATA_W  DM write data.
- dm_gnt_o  out  1  one-cycle grant pulse to DM.
- dm_rvalid_o  out  1  one-cycle pulse: DM read data valid, or write complete.
- dm_rdata_o  out  DATA_W  DM read data; 0 when not valid or on writes.
- mem_en_o  out  1  memory access strobe, registered.
- mem_we_o  out  1  memory write strobe, registered.
- mem_addr_o  out  ADDR_W  memory address, registered.
- mem_wdata_o  out  DATA_W  memory write data, registered.
- mem_rdata_i  in  DATA_W  memory read data.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; wait counter to 0; last_winner to IF.
  - All outputs are 0 in the cycle after the reset edge and while reset is held.
  - Grants are suppressed while reset is high.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If either request is high, grant the winner combinationally in the same cycle (gnt pulse for exactly that cycle).
  - Latch owner, we, addr and wdata into the mem_* registers. A granted IF access forces we=0 and wdata=0.
  - Next state is ISSUE.
  - With no request: stay in IDLE; mem_en_o=0.
- ISSUE (one cycle):
  - mem_en_o=1; mem_we_o, mem_addr_o, mem_wdata_o show the latched values.
  - Load counter with MEM_LATENCY-1; next state is WAIT.
- WAIT:
  - mem_en_o=0, mem_we_o=0. mem_addr_o and mem_wdata_o hold their values.
  - While counter ≠0, decrement.
  - When counter = 0 (exactly MEM_LATENCY cycles after the ISSUE cycle):
    - Pulse the owner's rvalid_o.
    - Owner's rdata_o = mem_rdata_i on reads, 0 on writes.
    - Next state is IDLE.
- Timing per transaction: grant at T, mem_en_o at T+1, rvalid at T+1+MEM_LATENCY, next grant possible at T+2+MEM_LATENCY.
- Arbitration:
  - DM_PRIORITY=1: dm_req_i wins every tie. IF can starve while DM is held high, by design.
  - DM_PRIORITY=0: on a tie, grant the requester that is not last_winner. last_winner updates on each grant.
  - A single requester always wins regardless of mode.
- Requests arriving in ISSUE or WAIT are not granted. They are evaluated on the first IDLE cycle.
- A requester keeping req high after its gnt makes a new request in the next IDLE cycle.
- Reset mid-transaction (ISSUE or WAIT): the transaction is abandoned; no rvalid is ever produced for it. The memory-side result is ignored.
- Only one of if_gnt_o/dm_gnt_o and only one of if_rvalid_o/dm_rvalid_o is high in any cycle.

Test Plan:
1. Hold reset=1 for 3 cycles with both req high → all outputs 0. In the first cycle after release (DM_PRIORITY=1) dm_gnt_o=1 and if_gnt_o=0.
2. IF read, MEM_LATENCY=2: if_req_i at T with addr 0x100; memory model returns 0xDEADBEEF → if_gnt_o at T; mem_en_o=1 with mem_addr_o=0x100 at T+1; if_rvalid_o=1 with if_rdata_o=0xDEADBEEF at T+3; busy_o low at T+4.
3. DM write: we=1, addr 0x200, wdata 0x1234 → mem_we_o=1 and mem_wdata_o=0x1234 for exactly 1 cycle at T+1; dm_rvalid_o pulse at T+3 with dm_rdata_o=0; if_rvalid_o stays 0.
4. DM_PRIORITY=1, both req held for 3 DM transactions → 3 dm_gnt_o and no if_gnt_o. After dm_req_i drops, the next grant is IF.
5. DM_PRIORITY=0, both req held for 4 transactions → grant order DM, IF, DM, IF, with grants spaced MEM_LATENCY+2 cycles apart. Repeat with MEM_LATENCY=1 → spacing 3 cycles.
6. Reset pulsed at T+2 of an IF read (state WAIT) → no if_rvalid_o at T+3; busy_o=0. A DM request made right after reset is granted in the first post-reset cycle and completes normally.
